// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: write-port driver for the 32x32 register file.
// Single-cycle ALU results always own the write port. Load responses wait in a
// small FIFO and drain into cycles that have no ALU write. Writes to x0 are
// suppressed. query_hit lets issue logic stall on a register that still has a
// queued load.
// Optional feature: define WB_LOAD_EXT_EN to select the byte/half lane and
// sign/zero-extend at enqueue. Without it, ld_data is stored unmodified.
module reg_writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  input  logic [1:0]               ld_size,
  input  logic                     ld_unsigned,
  input  logic [1:0]               ld_off,
  input  logic [4:0]               query_addr,
  output logic                     query_hit,
  output logic [4:0]               write_addr,
  output logic [31:0]              write_data,
  output logic                     reg_write,
  output logic [$clog2(DEPTH):0]   pend_count
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef WB_LOAD_EXT_EN
  // Lane select and extension of a raw memory word into its final register value.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic [1:0]        off,
    input logic              uns
  );
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh_b = raw >> {off, 3'b000};
    sh_h = raw >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (size)
      2'b00:   extend_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extend_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: extend_load = raw;
    endcase
  endfunction
`endif

  logic [4:0]        fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  logic              alu_wr_p0;
  logic              full_p0;
  logic              empty_p0;
  logic              push_p0;
  logic              pop_p0;
  logic [DATA_W-1:0] ld_ext_p0;

`ifdef WB_LOAD_EXT_EN
  assign ld_ext_p0 = extend_load(ld_data, ld_size, ld_off, ld_unsigned);
`else
  logic unused_ext_p0;
  assign ld_ext_p0     = ld_data;
  assign unused_ext_p0 = ^{ld_size, ld_off, ld_unsigned};
`endif

  // ---- stage p0: arbitration and FIFO handshake (combinational) ----
  assign alu_wr_p0 = alu_valid && (alu_rd != 5'd0);
  assign full_p0   = (pend_count == FULL_CNT);
  assign empty_p0  = (pend_count == '0);
  // Readiness ignores a same-cycle pop; held low while reset is asserted.
  assign ld_ready  = !reset && !full_p0;
  // Loads to x0 are handshaken but never enqueued.
  assign push_p0   = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign pop_p0    = !alu_wr_p0 && !empty_p0;

  // Report a queued load whose destination matches the queried register.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == query_addr) && (query_addr != 5'd0))
        query_hit = 1'b1;
    end
  end

  // FIFO payload storage; written only on push, never reset.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      fifo_rd[wptr]   <= ld_rd;
      fifo_data[wptr] <= ld_ext_p0;
    end
  end

  // FIFO control: pointers, per-entry valid flags and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_vld   <= '0;
      pend_count <= '0;
    end else begin
      if (pop_p0) begin
        fifo_vld[rptr] <= 1'b0;
        rptr           <= rptr + 1'b1;
      end
      if (push_p0) begin
        fifo_vld[wptr] <= 1'b1;
        wptr           <= wptr + 1'b1;
      end
      case ({push_p0, pop_p0})
        2'b10:   pend_count <= pend_count + 1'b1;
        2'b01:   pend_count <= pend_count - 1'b1;
        default: pend_count <= pend_count;
      endcase
    end
  end

  // ---- stage p1: registered write port; address/data hold when idle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_addr <= 5'd0;
      write_data <= '0;
    end else begin
      reg_write <= alu_wr_p0 || pop_p0;
      if (alu_wr_p0) begin
        write_addr <= alu_rd;
        write_data <= alu_data;
      end else if (pop_p0) begin
        write_addr <= fifo_rd[rptr];
        write_data <= fifo_data[rptr];
      end
    end
  end

endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Write-side driver for the 32x32 register file: merges single-cycle ALU results and variable-latency load responses into the file's single write port (`write_addr`, `write_data`, `reg_write`). Load responses are queued in a small FIFO and drained into cycles with no ALU write. Writes to x0 are suppressed. A query port exposes queued load destinations so issue logic can stall on RAW/WAW hazards.

## Interface
Parameters:
- `DEPTH`, default 2: load FIFO entries; power of two, 2..8.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `alu_valid` in 1: ALU result present this cycle; it cannot be stalled.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `ld_valid` in 1: load response offered.
- `ld_ready` out 1: load response accepted when `ld_valid && ld_ready`.
- `ld_rd` in 5: load destination register.
- `ld_data` in 32: raw memory word.
- `ld_size` in 2: load size; 00 byte, 01 half, 10/11 word.
- `ld_unsigned` in 1: 1 = zero-extend, 0 = sign-extend.
- `ld_off` in 2: byte offset within the word.
- `query_addr` in 5: register index to check against queued loads.
- `query_hit` out 1: combinational. 1 if any valid FIFO entry has `rd == query_addr` and `query_addr != 0`.
- `write_addr` out 5: register-file write address, registered.
- `write_data` out 32: register-file write data, registered.
- `reg_write` out 1: register-file write enable, registered.
- `pend_count` out $clog2(DEPTH)+1: number of valid FIFO entries.

## Operation
- **Write-port priority:** an ALU write is one with `alu_valid=1` and `alu_rd!=0`. When present it always owns the write port. Otherwise, a non-empty FIFO pops its head onto the port.
- **Non-writes:** an ALU result with `alu_rd==0` is not a write and does not block draining.
- **Load acceptance:** `ld_ready = !full`. Readiness does not account for a pop in the same cycle, so a full FIFO refuses a load even while draining.
- **Loads to x0:** accepted but not pushed; no state changes and no write occurs.
- **Extension:** applied at enqueue, so FIFO entries hold final 32-bit values (see Configuration).
- **Ordering:** FIFO entries drain in acceptance order. Ordering between ALU writes and queued loads is the issue stage's responsibility, which uses `query_hit` to stall. This block does not reorder or cancel writes.
- **Push and pop together:** when not full, a push and a pop may occur in the same cycle and `pend_count` is unchanged.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full/empty is decided by `pend_count`.

## Timing
- **Reset:** `reg_write=0`, `write_addr=0`, `write_data=0`, `pend_count=0`, `query_hit=0`, FIFO empty. `ld_ready=0` while `reset` is high and 1 in the first cycle after release.
- **Reset mid-operation:** discards all queued loads and any pending write; no partial write is emitted.
- **ALU latency:** an ALU write in cycle N appears on `write_*`/`reg_write` in cycle N+1, and the register file commits it at the end of N+1.
- **Load latency:** a load accepted in cycle N is visible to `query_hit` from N+1. If unblocked, it pops at the end of N+1 and `reg_write` is high in N+2. Each ALU write cycle adds one cycle of delay.
- **Deassertion:** `reg_write` is 0 in any cycle following one with no ALU write and an empty FIFO. `write_addr`/`write_data` then hold their last values.
- **`query_hit` lag:** reflects FIFO contents at the start of the cycle. A load accepted in the same cycle is not reported.

## Configuration
- **`WB_LOAD_EXT_EN` defined:**
  - byte loads select `ld_data[8*ld_off +: 8]`;
  - half loads select `ld_data[16*ld_off[1] +: 16]` (`ld_off[0]` ignored);
  - byte and half results are sign- or zero-extended per `ld_unsigned`;
  - word loads pass through.
- **`WB_LOAD_EXT_EN` undefined:** `ld_size`, `ld_off` and `ld_unsigned` are ignored and `ld_data` is stored unmodified. The ports remain present.

## Test plan
- **Reset:** assert `reset` mid-stream with 2 loads queued. Expect `reg_write=0` and `pend_count=0` immediately, `ld_ready=1` one cycle after release, and no write to either queued rd.
- **ALU only:** `alu_valid=1`, `alu_rd=5`, `alu_data=0x1234` in cycle N. Expect `reg_write=1`, `write_addr=5`, `write_data=0x1234` in N+1. Repeat with `alu_rd=0`: expect `reg_write=0`.
- **Collision:** load rd=7, data 0xAA accepted in N, with ALU writes in N+1..N+3. Expect `query_addr=7` to give `query_hit=1` from N+1, and the load written in N+5.
- **Full FIFO (DEPTH=2):** offer 3 back-to-back loads during continuous ALU writes. Expect `ld_ready=0` on the third, `pend_count=2`, and the third accepted only the cycle after the first drain.
- **Extension (`WB_LOAD_EXT_EN`):** `ld_data=0x80FF7F01`. Byte, signed, off=3 gives 0xFFFFFF80; half, unsigned, off=2 gives 0x000080FF. Without the macro, the same stimulus writes 0x80FF7F01.
- **x0 load:** load with `ld_rd=0`. Expect it accepted, `pend_count` unchanged, and no `reg_write`.
